clk_div_bank: RTL and testbench

Multi-channel programmable clock-enable/clock generator running from the 50 MHz board clock. Each of NUM_CH channels produces a 50%-duty divided clock and a one-cycle rising-edge tick, with a runtime-programmable half-period and per-channel enable. Divisor changes are staged and applied only at a period boundary, so outputs never glitch. It feeds the sensor ADC serial clock, PWM timebases and UART baud ticks from one block.

---
 rtl/clk_div_bank_if.sv | 16 +
 rtl/clk_div_bank.sv | 138 +++++++++++++
 tb/tb_clk_div_bank.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/clk_div_bank_if.sv
// Configuration port of clk_div_bank: one staged half-period write per accepted transfer.
// A transfer completes on a rising clock edge where cfg_valid and cfg_ready are both 1;
// the master holds cfg_ch/cfg_half stable while cfg_valid is high and not yet accepted.
interface clk_div_bank_if #(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = 8,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [DIV_W-1:0] cfg_half;

   modport master (output cfg_valid, output cfg_ch, output cfg_half, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_ch, input cfg_half, output cfg_ready);
endinterface

// File: rtl/clk_div_bank.sv
// Bank of independent 50%-duty clock dividers with staged, glitch-free half-period updates.
module clk_div_bank #(
   parameter int NUM_CH     = 4,
   parameter int DIV_W      = 8,
   parameter int RESET_HALF = 8
) (
   input  logic              clk_50MHz,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] ch_en,
   clk_div_bank_if.slave     cfg,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] pending,
   output logic [NUM_CH-1:0] ch_state_o
);

   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CH_SPAN = 1 << CH_W;
   localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);
   localparam logic [DIV_W-1:0] ZERO = '0;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_e;

   ch_state_e        st_q [NUM_CH];
   ch_state_e        st_d [NUM_CH];
   logic [DIV_W-1:0] h_q  [NUM_CH];
   logic [DIV_W-1:0] h_d  [NUM_CH];
   logic [DIV_W-1:0] s_q  [NUM_CH];
   logic [DIV_W-1:0] s_d  [NUM_CH];
   logic [DIV_W-1:0] c_q  [NUM_CH];
   logic [DIV_W-1:0] c_d  [NUM_CH];
   logic [NUM_CH-1:0] p_q, p_d;
   logic [NUM_CH-1:0] o_q, o_d;
   logic [NUM_CH-1:0] tk_q, tk_d;

   logic [CH_SPAN-1:0] p_ext;
   logic               cfg_fire;

   // Unused channel codes read as not-pending, so such writes are accepted and dropped.
   always_comb begin
      p_ext              = '0;
      p_ext[NUM_CH-1:0]  = p_q;
   end

   assign cfg.cfg_ready = ~p_ext[cfg.cfg_ch];
   assign cfg_fire      = cfg.cfg_valid & cfg.cfg_ready;

   always_comb begin
      st_d = st_q;
      h_d  = h_q;
      s_d  = s_q;
      c_d  = c_q;
      p_d  = p_q;
      o_d  = o_q;
      tk_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         case (st_q[i])
            IDLE: begin
               if (p_q[i]) begin
                  h_d[i] = s_q[i];
                  p_d[i] = 1'b0;
               end else if (ch_en[i] && (h_q[i] != ZERO)) begin
                  // The enabling cycle is the first counted cycle of the low phase.
                  st_d[i] = RUN;
                  if (c_q[i] == h_q[i] - ONE) begin
                     c_d[i]  = ZERO;
                     o_d[i]  = 1'b1;
                     tk_d[i] = 1'b1;
                  end else begin
                     c_d[i] = c_q[i] + ONE;
                  end
               end
            end
            RUN: begin
               if (!o_q[i] && !ch_en[i]) begin
                  st_d[i] = IDLE;
                  c_d[i]  = ZERO;
               end else if (c_q[i] == h_q[i] - ONE) begin
                  c_d[i] = ZERO;
                  o_d[i] = ~o_q[i];
                  if (!o_q[i]) begin
                     tk_d[i] = 1'b1;
                  end else begin
                     // High->low boundary: the only point a staged value may take effect.
                     if (p_q[i]) begin
                        h_d[i] = s_q[i];
                        p_d[i] = 1'b0;
                     end
                     if (!ch_en[i] || (p_q[i] && (s_q[i] == ZERO))) begin
                        st_d[i] = IDLE;
                     end
                  end
               end else begin
                  c_d[i] = c_q[i] + ONE;
               end
            end
            default: st_d[i] = IDLE;
         endcase
         if (cfg_fire && (cfg.cfg_ch == CH_W'(i))) begin
            s_d[i] = cfg.cfg_half;
            p_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            st_q[i] <= IDLE;
            h_q[i]  <= DIV_W'(RESET_HALF);
            s_q[i]  <= ZERO;
            c_q[i]  <= ZERO;
         end
         p_q  <= '0;
         o_q  <= '0;
         tk_q <= '0;
      end else begin
         st_q <= st_d;
         h_q  <= h_d;
         s_q  <= s_d;
         c_q  <= c_d;
         p_q  <= p_d;
         o_q  <= o_d;
         tk_q <= tk_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         ch_state_o[i] = (st_q[i] == RUN);
      end
   end

   assign clk_out = o_q;
   assign tick    = tk_q;
   assign pending = p_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: reset defaults, retune, backpressure, enable gating, extremes, async reset.
module tb_clk_div_bank;

   logic       clk;
   logic       rst_n;
   logic [3:0] ch_en;
   logic [3:0] clk_out;
   logic [3:0] tick;
   logic [3:0] pending;
   logic [3:0] ch_state;

   int n_cmp = 0;
   int n_err = 0;
   int e     = 0;

   clk_div_bank_if #(.NUM_CH(4), .DIV_W(8)) cfg_if ();

   clk_div_bank #(.NUM_CH(4), .DIV_W(8), .RESET_HALF(8)) dut (
      .clk_50MHz  (clk),
      .rst_n      (rst_n),
      .ch_en      (ch_en),
      .cfg        (cfg_if.slave),
      .clk_out    (clk_out),
      .tick       (tick),
      .pending    (pending),
      .ch_state_o (ch_state)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, e);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, e);
      end
   endtask

   // Edges are counted from reset release; values are sampled on the falling edge after edge t.
   task automatic run_to(input int t);
      while (e < t) begin
         @(negedge clk);
         e++;
      end
   endtask

   initial begin
      rst_n              = 1'b1;
      ch_en              = 4'hF;
      cfg_if.cfg_valid   = 1'b0;
      cfg_if.cfg_ch      = 2'd0;
      cfg_if.cfg_half    = 8'd0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk4("rst_clk_out", clk_out, 4'b0000);
      chk4("rst_tick", tick, 4'b0000);
      chk4("rst_pending", pending, 4'b0000);
      chk4("rst_state", ch_state, 4'b0000);
      chk1("rst_ready", cfg_if.cfg_ready, 1'b1);

      rst_n = 1'b1;
      e     = 0;
      run_to(7);  chk4("dflt_pre_rise", clk_out, 4'b0000);
      run_to(8);  chk4("dflt_rise", clk_out, 4'b1111);
                  chk4("dflt_tick", tick, 4'b1111);
      run_to(9);  chk4("dflt_tick_off", tick, 4'b0000);
      run_to(15); chk4("dflt_high_end", clk_out, 4'b1111);
      run_to(16); chk4("dflt_fall", clk_out, 4'b0000);
      run_to(23); chk4("dflt_low_end", clk_out, 4'b0000);
      run_to(24); chk4("dflt_rise2", clk_out, 4'b1111);
                  chk4("dflt_tick2", tick, 4'b1111);

      // Retune ch0 to 3 in the middle of a high phase, then try a second write while pending.
      run_to(26);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = 2'd0;
      cfg_if.cfg_half  = 8'd3;
      #1 chk1("retune_ready", cfg_if.cfg_ready, 1'b1);
      run_to(27); chk4("retune_pending", pending, 4'b0001);
      cfg_if.cfg_half = 8'd5;
      #1 chk1("bp_ready_ch0", cfg_if.cfg_ready, 1'b0);
      run_to(28); chk4("bp_not_taken", pending, 4'b0001);
      cfg_if.cfg_ch   = 2'd1;
      cfg_if.cfg_half = 8'd4;
      #1 chk1("bp_ready_ch1", cfg_if.cfg_ready, 1'b1);
      run_to(29);
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_ch    = 2'd0;
      chk4("bp_ch1_taken", pending, 4'b0011);
      run_to(31); chk4("retune_high_held", clk_out, 4'b1111);
      #1 chk1("retune_ready_hold", cfg_if.cfg_ready, 1'b0);
      run_to(32); chk4("retune_fall", clk_out, 4'b0000);
                  chk4("retune_applied", pending, 4'b0000);
      run_to(34); chk4("retune_low3", clk_out, 4'b0000);
      run_to(35); chk4("retune_rise_ch0", clk_out, 4'b0001);
                  chk4("retune_tick_ch0", tick, 4'b0001);
      run_to(36); chk4("retune_rise_ch1", clk_out, 4'b0011);
                  chk4("retune_tick_ch1", tick, 4'b0010);
      run_to(38); chk4("retune_fall_ch0", clk_out, 4'b0010);
      run_to(40); chk4("mix_40_clk", clk_out, 4'b1100);
                  chk4("mix_40_tick", tick, 4'b1100);

      // Drop ch2 two cycles into its high phase.
      run_to(41); ch_en = 4'b1011;
      run_to(47); chk1("gate_high_held", clk_out[2], 1'b1);
      run_to(48); chk1("gate_fall", clk_out[2], 1'b0);
      run_to(50); chk1("gate_idle", ch_state[2], 1'b0);
      run_to(56); chk4("gate_56_clk", clk_out, 4'b1000);
                  chk4("gate_56_tick", tick, 4'b1000);
      run_to(60); ch_en = 4'hF;
      run_to(67); chk1("reen_pre_rise", clk_out[2], 1'b0);
      run_to(68); chk4("reen_68_clk", clk_out, 4'b0110);
                  chk4("reen_68_tick", tick, 4'b0110);

      // ch1 to H=1.
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = 2'd1;
      cfg_if.cfg_half  = 8'd1;
      #1 chk1("h1_ready", cfg_if.cfg_ready, 1'b1);
      run_to(69);
      cfg_if.cfg_valid = 1'b0;
      chk4("h1_pending", pending, 4'b0010);
      run_to(72); chk1("h1_fall", clk_out[1], 1'b0);
                  chk4("h1_applied", pending, 4'b0000);
      run_to(73); chk1("h1_rise", clk_out[1], 1'b1);
                  chk1("h1_tick", tick[1], 1'b1);
      run_to(74); chk1("h1_low", clk_out[1], 1'b0);
                  chk1("h1_tick_off", tick[1], 1'b0);
      run_to(75); chk1("h1_rise2", clk_out[1], 1'b1);
                  chk1("h1_tick2", tick[1], 1'b1);

      // ch0 parked with H=0, then restarted with H=255.
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = 2'd0;
      cfg_if.cfg_half  = 8'd0;
      run_to(76);
      cfg_if.cfg_valid = 1'b0;
      chk4("h0_pending", pending, 4'b0001);
      run_to(79); chk1("h0_last_high", clk_out[0], 1'b1);
      run_to(80); chk1("h0_fall", clk_out[0], 1'b0);
                  chk4("h0_applied", pending, 4'b0000);
                  chk1("h0_idle", ch_state[0], 1'b0);
      run_to(86); chk1("h0_parked", clk_out[0], 1'b0);
                  chk1("h0_no_tick", tick[0], 1'b0);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_half  = 8'd255;
      run_to(87);
      cfg_if.cfg_valid = 1'b0;
      chk4("h255_pending", pending, 4'b0001);
      run_to(88);  chk4("h255_applied_idle", pending, 4'b0000);
      run_to(342); chk1("h255_pre_rise", clk_out[0], 1'b0);
      run_to(343); chk1("h255_rise", clk_out[0], 1'b1);
                   chk1("h255_tick", tick[0], 1'b1);
      run_to(597); chk1("h255_high_end", clk_out[0], 1'b1);
      run_to(598); chk1("h255_fall", clk_out[0], 1'b0);
      run_to(852); chk1("h255_low_end", clk_out[0], 1'b0);
      run_to(853); chk1("h255_rise2", clk_out[0], 1'b1);

      // Asynchronous reset between edges, with a write to ch3 still staged.
      run_to(860);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = 2'd3;
      cfg_if.cfg_half  = 8'd2;
      run_to(861);
      cfg_if.cfg_valid = 1'b0;
      chk4("arst_pre_pending", pending, 4'b1000);
      run_to(862);
      chk1("arst_pre_clk3", clk_out[3], 1'b1);
      #3 rst_n = 1'b0;
      #1;
      chk4("arst_clk_out", clk_out, 4'b0000);
      chk4("arst_tick", tick, 4'b0000);
      chk4("arst_pending", pending, 4'b0000);
      chk1("arst_ready", cfg_if.cfg_ready, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      e     = 0;
      run_to(7);  chk4("post_pre_rise", clk_out, 4'b0000);
      run_to(8);  chk4("post_rise", clk_out, 4'b1111);
                  chk4("post_tick", tick, 4'b1111);
                  chk4("post_pending", pending, 4'b0000);
      run_to(16); chk4("post_fall", clk_out, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
